// File: rtl/uart_script_player.sv
// uart_script_player
//   Plays a small stored script of UART actions onto a serial TxD line.
//   Each script entry either transmits a byte (8N1 frame), waits for a
//   byte returned by the device under test, stops playback, or does nothing.
//   Sequencing is driven by handshakes rather than fixed delays.
//
// Ports
//   clk, reset       system clock, synchronous active-high reset
//   wr_en/wr_addr/   script write port {op[1:0], byte[7:0]}; writes are
//   wr_data          dropped while busy
//   start, abort     one-cycle control pulses
//   baud_div         clocks per bit (0 behaves as 1), sampled per SEND entry
//   gap              idle clocks between frames, sampled per SEND entry
//   wait_to          WAIT timeout in clocks, 0 waits forever
//   rx_valid/rx_data received byte strobe from an external UART receiver
//   TxD              serial output, idle high
//   busy, done, err  status; done and err are sticky until the next start
//   pc               current (or failing) script index

module uart_script_player #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DIV_W = 16,
  parameter int TO_W  = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [9:0]       wr_data,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [DIV_W-1:0] gap,
  input  logic [TO_W-1:0]  wait_to,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             TxD,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AW-1:0]    pc
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_START, S_DATA, S_STOPB, S_GAP, S_WAIT, S_DONE, S_ERR
  } state_t;

  localparam logic [1:0] OP_SEND = 2'b00;
  localparam logic [1:0] OP_WAIT = 2'b01;
  localparam logic [1:0] OP_STOP = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  logic [9:0]       r_mem [DEPTH];
  logic [9:0]       r_entry;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_pc;
  logic [AW-1:0]    w_pc_nxt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_gap;
  logic [DIV_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic [TO_W-1:0]  r_to;
  logic             r_txd;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic w_bit_end;
  logic w_gap_end;
  logic w_match;
  logic w_timeout;
  logic w_abort;
  logic w_last;
  logic w_adv;

  function automatic logic f_is_busy(input state_t s);
    return !(s == S_IDLE || s == S_DONE || s == S_ERR);
  endfunction

  assign w_bit_end = (r_cnt == r_div - DIV_W'(1));
  // GAP holds gap-1 clocks; the following FETCH cycle is the last idle clock,
  // so the line idles exactly max(gap,1) clocks between frames.
  assign w_gap_end = (r_cnt == r_gap - DIV_W'(2));
  assign w_match   = rx_valid && (rx_data == r_entry[7:0]);
  assign w_timeout = (wait_to != '0) && (r_to == wait_to - TO_W'(1));
  assign w_abort   = abort && r_busy;
  assign w_last    = (r_pc == AW'(DEPTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_adv       = 1'b0;
    if (w_abort) begin
      w_state_nxt = S_ERR;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = S_FETCH;
            w_pc_nxt    = '0;
          end
        end
        S_FETCH: begin
          case (r_entry[9:8])
            OP_SEND: w_state_nxt = S_START;
            OP_WAIT: w_state_nxt = S_WAIT;
            OP_STOP: w_state_nxt = S_DONE;
            OP_NOP:  w_adv       = 1'b1;
            default: w_adv       = 1'b1;
          endcase
        end
        S_START: if (w_bit_end) w_state_nxt = S_DATA;
        S_DATA:  if (w_bit_end && r_bit == 3'd7) w_state_nxt = S_STOPB;
        S_STOPB: begin
          if (w_bit_end) begin
            if (r_gap > DIV_W'(1)) w_state_nxt = S_GAP;
            else                   w_adv       = 1'b1;
          end
        end
        S_GAP: if (w_gap_end) w_adv = 1'b1;
        S_WAIT: begin
          // A match in the final timeout cycle still advances.
          if (w_match)        w_adv       = 1'b1;
          else if (w_timeout) w_state_nxt = S_ERR;
        end
        S_DONE:  w_state_nxt = S_IDLE;
        S_ERR:   w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
      if (w_adv) begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_pc_nxt    = r_pc + AW'(1);
          w_state_nxt = S_FETCH;
        end
      end
    end
  end

  // Control registers: state, index, status, serial line
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_busy  <= f_is_busy(w_state_nxt);
      if (w_state_nxt == S_DONE)                           r_done <= 1'b1;
      else if (r_state == S_IDLE && w_state_nxt == S_FETCH) r_done <= 1'b0;
      if (w_state_nxt == S_ERR)                            r_err  <= 1'b1;
      else if (r_state == S_IDLE && w_state_nxt == S_FETCH) r_err  <= 1'b0;
      // TxD is registered one cycle behind the frame state; abort forces the
      // line high on the very next cycle regardless of frame position.
      if (w_abort) begin
        r_txd <= 1'b1;
      end else begin
        case (r_state)
          S_START: r_txd <= 1'b0;
          S_DATA:  r_txd <= r_shift[0];
          default: r_txd <= 1'b1;
        endcase
      end
    end
  end

  // Datapath: script memory, registered read, bit/gap/timeout counters
  always_ff @(posedge clk) begin
    if (wr_en && !r_busy) r_mem[wr_addr] <= wr_data;
    r_entry <= r_mem[w_pc_nxt];
    case (r_state)
      S_FETCH: begin
        r_cnt <= '0;
        r_bit <= '0;
        r_to  <= '0;
        if (r_entry[9:8] == OP_SEND) begin
          r_shift <= r_entry[7:0];
          r_div   <= (baud_div == '0) ? DIV_W'(1) : baud_div;
          r_gap   <= gap;
        end
      end
      S_START, S_STOPB: begin
        r_cnt <= w_bit_end ? '0 : r_cnt + DIV_W'(1);
      end
      S_DATA: begin
        if (w_bit_end) begin
          r_cnt   <= '0;
          r_bit   <= r_bit + 3'd1;
          r_shift <= {1'b0, r_shift[7:1]};
        end else begin
          r_cnt <= r_cnt + DIV_W'(1);
        end
      end
      S_GAP:   r_cnt <= r_cnt + DIV_W'(1);
      S_WAIT:  r_to  <= r_to + TO_W'(1);
      default: ;
    endcase
  end

  assign TxD  = r_txd;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;
  assign pc   = r_pc;

endmodule

// File: tb/tb_uart_script_player.sv
// Bench for uart_script_player. A timeline model derives, from the script
// and the knobs, what every output must be on every cycle after a start
// pulse (cycle 0). Direct sequences cover abort, wait-forever and reset.
module tb_uart_script_player;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DIV_W = 16;
  localparam int TO_W  = 24;
  localparam int MAXC  = 400;

  localparam logic [1:0] SEND   = 2'b00;
  localparam logic [1:0] WAITOP = 2'b01;
  localparam logic [1:0] STOPOP = 2'b10;
  localparam logic [1:0] NOPOP  = 2'b11;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [9:0]       wr_data;
  logic             start;
  logic             abort;
  logic [DIV_W-1:0] baud_div;
  logic [DIV_W-1:0] gap;
  logic [TO_W-1:0]  wait_to;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             TxD;
  logic             busy;
  logic             done;
  logic             err;
  logic [AW-1:0]    pc;

  always #5 clk = ~clk;

  uart_script_player #(.DEPTH(DEPTH), .AW(AW), .DIV_W(DIV_W), .TO_W(TO_W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort), .baud_div(baud_div), .gap(gap), .wait_to(wait_to),
    .rx_valid(rx_valid), .rx_data(rx_data), .TxD(TxD), .busy(busy), .done(done),
    .err(err), .pc(pc)
  );

  int nvec  = 0;
  int nfail = 0;

  logic [9:0] scr [DEPTH];
  typedef struct { int cyc; logic [7:0] data; } rx_ev_t;
  rx_ev_t rxq[$];
  int start_at, wr_at, div_at;
  logic [DIV_W-1:0] div_alt;

  logic          exp_txd [MAXC];
  logic          exp_busy[MAXC];
  logic          exp_done[MAXC];
  logic          exp_err [MAXC];
  logic [AW-1:0] exp_pc  [MAXC];
  logic          d_txd [MAXC];
  logic          d_busy[MAXC];
  logic          d_done[MAXC];
  logic          d_err [MAXC];
  logic [AW-1:0] d_pc  [MAXC];

  task automatic chk(input string name, input int act, input int req);
    nvec++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic fill_pc(input int a, input int b, input int p);
    for (int c = a; c < b && c < MAXC; c++) exp_pc[c] = AW'(p);
  endtask

  task automatic fill_end(input int at, input bit is_err, input int p);
    for (int c = at; c < MAXC; c++) begin
      exp_busy[c] = 1'b0;
      exp_done[c] = !is_err;
      exp_err[c]  = is_err;
      exp_pc[c]   = AW'(p);
    end
  endtask

  // Timeline model: frame of byte fetched at cycle f shows its start bit on
  // TxD at f+2; the line idles max(gap,1) clocks before the next start bit.
  task automatic build_model();
    int f, p, fn, r, bw, idx, to;
    bit fin;
    logic [9:0] e;
    logic bv;
    for (int c = 0; c < MAXC; c++) begin
      exp_txd[c] = 1'b1; exp_busy[c] = 1'b1; exp_done[c] = 1'b0;
      exp_err[c] = 1'b0; exp_pc[c] = '0;
    end
    to = int'(wait_to);
    f = 1; p = 0; fin = 1'b0;
    while (!fin && f < MAXC) begin
      e  = scr[p];
      fn = f + 1;
      case (e[9:8])
        SEND: begin
          bw = (baud_div == 0) ? 1 : int'(baud_div);
          for (int i = 0; i < 10; i++) begin
            if (i == 0)      bv = 1'b0;
            else if (i == 9) bv = 1'b1;
            else             bv = e[i-1];
            for (int k = 0; k < bw; k++) begin
              idx = f + 2 + i*bw + k;
              if (idx < MAXC) exp_txd[idx] = bv;
            end
          end
          fn = f + 10*bw + ((gap == 0) ? 1 : int'(gap));
        end
        WAITOP: begin
          r = -1;
          foreach (rxq[j])
            if (r < 0 && rxq[j].data == e[7:0] && rxq[j].cyc >= f + 1 &&
                (to == 0 || rxq[j].cyc <= f + to)) r = rxq[j].cyc;
          if (r >= 0) fn = r + 1;
          else if (to != 0) begin
            fill_pc(f, f + 1 + to, p); fill_end(f + 1 + to, 1'b1, p); fin = 1'b1;
          end else begin
            fill_pc(f, MAXC, p); fin = 1'b1;
          end
        end
        STOPOP: begin
          fill_pc(f, f + 1, p); fill_end(f + 1, 1'b0, p); fin = 1'b1;
        end
        default: fn = f + 1;
      endcase
      if (!fin) begin
        fill_pc(f, fn, p);
        if (p == DEPTH - 1) begin
          fill_end(fn, 1'b0, p); fin = 1'b1;
        end else begin
          p++; f = fn;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_knobs();
    start_at = -1; wr_at = -1; div_at = -1; div_alt = '0;
    rxq.delete();
    wait_to = '0; gap = '0;
    for (int a = 0; a < DEPTH; a++) scr[a] = {STOPOP, 8'h00};
  endtask

  task automatic load_script();
    for (int a = 0; a < DEPTH; a++) begin
      step(); wr_en = 1'b1; wr_addr = AW'(a); wr_data = scr[a];
    end
    step(); wr_en = 1'b0;
  endtask

  // Start at cycle 0, then compare all outputs on cycles 1..n.
  task automatic run(input string tag, input int n);
    build_model();
    load_script();
    start = 1'b1;
    for (int c = 1; c <= n; c++) begin
      step();
      start   = (c == start_at);
      wr_en   = (c == wr_at);
      wr_addr = AW'(1);
      wr_data = {SEND, 8'hFF};
      if (c == div_at) baud_div = div_alt;
      rx_valid = 1'b0; rx_data = 8'h00;
      foreach (rxq[j]) if (rxq[j].cyc == c) begin rx_valid = 1'b1; rx_data = rxq[j].data; end
      @(negedge clk);
      d_txd[c] = TxD; d_busy[c] = busy; d_done[c] = done; d_err[c] = err; d_pc[c] = pc;
      chk($sformatf("%s TxD c%0d", tag, c),  int'(TxD),  int'(exp_txd[c]));
      chk($sformatf("%s busy c%0d", tag, c), int'(busy), int'(exp_busy[c]));
      chk($sformatf("%s done c%0d", tag, c), int'(done), int'(exp_done[c]));
      chk($sformatf("%s err c%0d", tag, c),  int'(err),  int'(exp_err[c]));
      chk($sformatf("%s pc c%0d", tag, c),   int'(pc),   int'(exp_pc[c]));
    end
    step();
    start = 1'b0; wr_en = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    step(); start = 1'b1;   // cycle 0
    step(); start = 1'b0;   // cycle 1
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    abort = 1'b0; baud_div = 16'd4; gap = '0; wait_to = '0;
    rx_valid = 1'b0; rx_data = '0;
    clear_knobs();
    repeat (3) step();
    @(negedge clk);
    chk("reset TxD", int'(TxD), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset err", int'(err), 0);
    chk("reset pc", int'(pc), 0);
    step(); reset = 1'b0;

    // T1: SEND 'm', STOP; divisor change mid-frame must not matter
    clear_knobs();
    scr[0] = {SEND, 8'h6D}; scr[1] = {STOPOP, 8'h00};
    baud_div = 16'd4; div_at = 10; div_alt = 16'd9;
    run("t1", 50);
    chk("t1 idle before start bit", int'(d_txd[2]), 1);
    chk("t1 start bit at c3", int'(d_txd[3]), 0);
    chk("t1 start bit at c6", int'(d_txd[6]), 0);
    chk("t1 bit0", int'(d_txd[7]), 1);
    chk("t1 bit1", int'(d_txd[11]), 0);
    chk("t1 bit7", int'(d_txd[38]), 0);
    chk("t1 stop", int'(d_txd[39]), 1);
    chk("t1 busy c42", int'(d_busy[42]), 1);
    chk("t1 done c43", int'(d_done[43]), 1);
    chk("t1 busy c43", int'(d_busy[43]), 0);

    // T2: three frames separated by gap=8
    clear_knobs();
    scr[0] = {SEND, 8'h20}; scr[1] = {SEND, 8'h30}; scr[2] = {SEND, 8'h0A};
    scr[3] = {STOPOP, 8'h00};
    baud_div = 16'd2; gap = 16'd8;
    run("t2", 95);
    chk("t2 stop last clk", int'(d_txd[22]), 1);
    chk("t2 idle 8th clk", int'(d_txd[30]), 1);
    chk("t2 next start", int'(d_txd[31]), 0);
    chk("t2 final pc", int'(d_pc[86]), 3);
    chk("t2 done", int'(d_done[86]), 1);

    // T3: WAIT 'g' with a stray byte, write and start while busy
    clear_knobs();
    scr[0] = {WAITOP, 8'h67}; scr[1] = {SEND, 8'h31}; scr[2] = {STOPOP, 8'h00};
    baud_div = 16'd3;
    rxq.push_back('{10, 8'h41});
    rxq.push_back('{20, 8'h67});
    wr_at = 5; start_at = 30;
    run("t3", 60);
    chk("t3 idle 2 after match", int'(d_txd[22]), 1);
    chk("t3 start 3 after match", int'(d_txd[23]), 0);
    chk("t3 done", int'(d_done[53]), 1);

    // T4: WAIT timeout
    clear_knobs();
    scr[0] = {WAITOP, 8'h67};
    wait_to = 24'd100;
    run("t4", 110);
    chk("t4 err before", int'(d_err[101]), 0);
    chk("t4 err at 100", int'(d_err[102]), 1);
    chk("t4 pc", int'(d_pc[102]), 0);
    chk("t4 busy", int'(d_busy[102]), 0);

    // T4b: match in the last timeout cycle wins; NOP advances
    clear_knobs();
    scr[0] = {WAITOP, 8'h67}; scr[1] = {NOPOP, 8'h00}; scr[2] = {STOPOP, 8'h00};
    wait_to = 24'd100;
    rxq.push_back('{101, 8'h67});
    run("t4b", 110);
    chk("t4b done early", int'(d_done[103]), 0);
    chk("t4b done", int'(d_done[104]), 1);
    chk("t4b err", int'(d_err[104]), 0);
    chk("t4b pc", int'(d_pc[104]), 2);

    // T5: wait forever, then abort beats a simultaneous match
    clear_knobs();
    scr[0] = {WAITOP, 8'h67};
    load_script();
    pulse_start();
    for (int c = 2; c <= 10000; c++) step();
    @(negedge clk);
    chk("t5 busy after 10000", int'(busy), 1);
    chk("t5 TxD after 10000", int'(TxD), 1);
    chk("t5 err after 10000", int'(err), 0);
    step(); abort = 1'b1; rx_valid = 1'b1; rx_data = 8'h67;
    step(); abort = 1'b0; rx_valid = 1'b0;
    @(negedge clk);
    chk("t5 abort err", int'(err), 1);
    chk("t5 abort done", int'(done), 0);
    chk("t5 abort busy", int'(busy), 0);

    // T6: abort mid-DATA of 0x55, then replay
    clear_knobs();
    scr[0] = {SEND, 8'h55}; scr[1] = {STOPOP, 8'h00};
    baud_div = 16'd4;
    load_script();
    pulse_start();
    for (int c = 2; c <= 20; c++) step();
    abort = 1'b1;
    @(negedge clk);
    chk("t6 TxD bit3 before abort", int'(TxD), 0);
    step(); abort = 1'b0;
    @(negedge clk);
    chk("t6 TxD after abort", int'(TxD), 1);
    chk("t6 err", int'(err), 1);
    chk("t6 busy", int'(busy), 0);
    chk("t6 pc", int'(pc), 0);
    step(); step();
    run("t6r", 50);
    chk("t6 replay clears err", int'(d_err[1]), 0);

    // T7: full script of SENDs, baud_div=0 acts as 1, no wrap
    clear_knobs();
    for (int a = 0; a < DEPTH; a++) scr[a] = {SEND, 8'(8'h30 + a)};
    baud_div = 16'd0;
    run("t7", 185);
    chk("t7 last start idle", int'(d_txd[167]), 1);
    chk("t7 last start bit", int'(d_txd[168]), 0);
    chk("t7 busy before done", int'(d_busy[176]), 1);
    chk("t7 done", int'(d_done[177]), 1);
    chk("t7 pc", int'(d_pc[177]), 15);

    // T8: reset mid-frame during replay
    load_script();
    pulse_start();
    for (int c = 2; c <= 50; c++) step();
    reset = 1'b1;
    @(negedge clk);
    chk("t8 busy before reset", int'(busy), 1);
    chk("t8 pc before reset", int'(pc), 4);
    step(); reset = 1'b0;
    @(negedge clk);
    chk("t8 TxD", int'(TxD), 1);
    chk("t8 busy", int'(busy), 0);
    chk("t8 done", int'(done), 0);
    chk("t8 err", int'(err), 0);
    chk("t8 pc", int'(pc), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/uart_script_player.md
Name: uart_script_player

Overview:
- Synthesizable, parametrised successor to the bench-side UART stimulus task: plays a stored script of UART actions into a computer's RxD line.
- Script entries either send a byte or wait for a specific byte returned by the device under test; replaces fixed-delay command injection with handshake-driven sequencing.
- Sits beside the comp instance in benches and on-board self-test wrappers.
- Drives TxD directly; takes received bytes from an existing UART receiver via a valid/data strobe.

Parameters:
- DEPTH, 16, number of script entries (power of two).
- AW, 4, script address width, log2(DEPTH).
- DIV_W, 16, width of baud divisor and gap counters.
- TO_W, 24, width of wait-timeout counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  script write strobe; ignored while busy.
- wr_addr  in  AW  script write address.
- wr_data  in  10  script entry {op[1:0], byte[7:0]}.
- start  in  1  one-cycle pulse; begins playback at entry 0.
- abort  in  1  one-cycle pulse; stops playback.
- baud_div  in  DIV_W  clocks per bit; 0 treated as 1.
- gap  in  DIV_W  idle clocks inserted after each stop bit.
- wait_to  in  TO_W  wait timeout in clocks; 0 = wait forever.
- rx_valid  in  1  one-cycle strobe from receiver.
- rx_data  in  8  received byte, valid with rx_valid.
- TxD  out  1  serial output, idle high.
- busy  out  1  playback in progress.
- done  out  1  sticky; set on STOP op or end of script.
- err  out  1  sticky; set on wait timeout or abort.
- pc  out  AW  current script index.

Behaviour:
Reset:
- TxD=1, busy=0, done=0, err=0, pc=0, state IDLE.
- Script memory contents are not reset.
- A reset mid-frame forces TxD=1 in the next cycle.

Script ops:
- 00 SEND byte.
- 01 WAIT until a received byte equals byte.
- 10 STOP.
- 11 NOP (advance only).

States: IDLE, FETCH, START, DATA, STOPB, GAP, WAIT, DONE, ERR.
- IDLE: start clears done/err, sets pc=0, busy=1, goes to FETCH next cycle.
- FETCH: one cycle; reads entry[pc] (registered read), dispatches on op.
- SEND frame: START (TxD=0), then 8 DATA bits LSB first, then STOPB (TxD=1). Each bit lasts max(baud_div,1) clocks. Frame length = 10*max(baud_div,1) clocks.
- GAP: gap clocks with TxD=1 (0 = skip), then advance.
- WAIT:
  - rx_valid with rx_data==byte -> advance.
  - Non-matching bytes are ignored.
  - Timeout counter starts at WAIT entry; reaching wait_to (nonzero) -> ERR.
  - rx_valid in the same cycle as timeout: the match wins.
- Advance:
  - If pc==DEPTH-1 -> DONE (no wrap). Otherwise pc+1 -> FETCH.
  - STOP op -> DONE. NOP -> advance.
- DONE: busy=0, done=1, return to IDLE.
- ERR: busy=0, err=1, pc holds the failing index, return to IDLE.
- abort:
  - Any busy state -> ERR next cycle; TxD=1 immediately, even mid-frame.
  - abort has priority over start and over a WAIT match.
- start while busy is ignored.
- baud_div and gap are sampled at each FETCH of a SEND entry; changes mid-frame do not affect that frame.
- wr_en while busy has no effect.
- Latency: start pulse at cycle 0 -> start bit visible on TxD at cycle 3 (IDLE->FETCH->START register).

Test Plan:
- Load {SEND 'm'(0x6D), STOP}, baud_div=4, gap=0, pulse start -> TxD low at cycle 3 for 4 clks; bits 1,0,1,1,0,1,1,0; stop high; done=1 and busy=0 about 2 clks after the stop bit.
- Script {SEND 0x20, SEND 0x30, SEND 0x0A, STOP}, gap=8 -> three frames, exactly 8 idle-high clocks between each stop bit and the next start bit; pc ends at 3.
- Script {WAIT 'g'(0x67), SEND 0x31, STOP}, rx bytes 0x41 then 0x67 -> nothing sent after 0x41; frame 0x31 starts 3 clks after the 0x67 strobe; done=1.
- WAIT with wait_to=100 and no rx -> err=1 at 100 clks after WAIT entry, pc=0, TxD stays high; same test with wait_to=0 -> still busy after 10000 clks.
- abort pulse mid-DATA of a 0x55 frame -> TxD=1 next cycle, err=1, busy=0; a subsequent start replays from pc=0 and clears err.
- Full script of DEPTH SEND entries with no STOP -> done after entry DEPTH-1, pc=DEPTH-1, no wrap; reset asserted mid-playback -> all outputs return to reset values next cycle.
